// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding,
// default reset vector and opcode field helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;

    function automatic logic [5:0] getOpCode(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble beats load, otherwise the contents hold.
module if_id_register
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] nextInstr,
    input  logic [31:0] nextPcPlus4,
    output logic [31:0] instr,
    output logic [31:0] pcPlus4,
    output logic        valid
);

    logic [31:0] instrR;
    logic [31:0] pcPlus4R;
    logic        validR;

    // Pipeline register update; a bubble leaves pcPlus4 untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instrR   <= NOP_INSTR;
            pcPlus4R <= 32'h0000_0000;
            validR   <= 1'b0;
        end else if (bubble) begin
            instrR   <= NOP_INSTR;
            pcPlus4R <= pcPlus4R;
            validR   <= 1'b0;
        end else if (load) begin
            instrR   <= nextInstr;
            pcPlus4R <= nextPcPlus4;
            validR   <= 1'b1;
        end else begin
            instrR   <= instrR;
            pcPlus4R <= pcPlus4R;
            validR   <= validR;
        end
    end

    assign instr   = instrR;
    assign pcPlus4 = pcPlus4R;
    assign valid   = validR;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM with a one-entry hold buffer for
// data returned under stall, redirect handling and delivered-instruction count.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [25:0] jumpIndex,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic [5:0]  opCode,
    output logic [31:0] fetchCount
);

    fetch_state_e stateR;
    fetch_state_e nextStateS;
    logic [31:0]  pcR;
    logic [31:0]  nextPcS;
    logic [31:0]  pcPlus4S;
    logic [31:0]  fetchCountR;
    logic [31:0]  holdInstrR;
    logic [31:0]  holdPcPlus4R;
    logic         imemReqR;
    logic         redirectS;
    logic [31:0]  targetS;
    logic         ifLoadS;
    logic         ifBubbleS;
    logic [31:0]  ifInstrS;
    logic [31:0]  ifPcPlus4S;
    logic         holdCaptureS;
    logic         holdClearS;
    logic         countIncS;

    assign pcPlus4S  = pcR + 32'd4;
    assign redirectS = branchTaken | jump;
    // Branch wins over jump: it belongs to the older instruction.
    assign targetS   = branchTaken ? (branchTarget & 32'hFFFF_FFFC)
                                   : {ifIdPcPlus4[31:28], jumpIndex, 2'b00};

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        nextStateS   = stateR;
        nextPcS      = pcR;
        ifLoadS      = 1'b0;
        ifBubbleS    = 1'b0;
        ifInstrS     = imemData;
        ifPcPlus4S   = pcPlus4S;
        holdCaptureS = 1'b0;
        holdClearS   = 1'b0;
        countIncS    = 1'b0;
        case (stateR)
            ST_IDLE: begin
                nextStateS = ST_WAIT;
            end
            ST_WAIT: begin
                if (imemReady) begin
                    nextPcS = pcPlus4S;
                    if (stall) begin
                        holdCaptureS = 1'b1;
                        nextStateS   = ST_HOLD;
                    end else begin
                        ifLoadS   = 1'b1;
                        countIncS = 1'b1;
                    end
                end else if (!stall) begin
                    ifBubbleS = 1'b1;
                end else begin
                    ifBubbleS = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    ifLoadS    = 1'b1;
                    ifInstrS   = holdInstrR;
                    ifPcPlus4S = holdPcPlus4R;
                    countIncS  = 1'b1;
                    nextStateS = ST_WAIT;
                end else begin
                    nextStateS = ST_HOLD;
                end
            end
            default: begin
                nextStateS = ST_IDLE;
            end
        endcase
        // Redirect overrides stall and discards any returned or held data.
        if (redirectS) begin
            nextPcS      = targetS;
            ifLoadS      = 1'b0;
            ifBubbleS    = 1'b1;
            holdCaptureS = 1'b0;
            holdClearS   = 1'b1;
            countIncS    = 1'b0;
            nextStateS   = ST_WAIT;
        end else begin
            holdClearS = 1'b0;
        end
    end

    // State, PC, counter, request and hold buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR       <= ST_IDLE;
            pcR          <= {RESET_PC[31:2], 2'b00};
            fetchCountR  <= 32'h0000_0000;
            holdInstrR   <= NOP_INSTR;
            holdPcPlus4R <= 32'h0000_0000;
            imemReqR     <= 1'b0;
        end else begin
            stateR      <= nextStateS;
            pcR         <= nextPcS;
            fetchCountR <= countIncS ? fetchCountR + 32'd1 : fetchCountR;
            imemReqR    <= (nextStateS == ST_WAIT);
            if (holdClearS) begin
                holdInstrR   <= NOP_INSTR;
                holdPcPlus4R <= 32'h0000_0000;
            end else if (holdCaptureS) begin
                holdInstrR   <= imemData;
                holdPcPlus4R <= pcPlus4S;
            end else begin
                holdInstrR   <= holdInstrR;
                holdPcPlus4R <= holdPcPlus4R;
            end
        end
    end

    if_id_register u_ifId (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifLoadS),
        .bubble      (ifBubbleS),
        .nextInstr   (ifInstrS),
        .nextPcPlus4 (ifPcPlus4S),
        .instr       (ifIdInstr),
        .pcPlus4     (ifIdPcPlus4),
        .valid       (ifIdValid)
    );

    assign pc         = pcR;
    assign imemAddr   = pcR;
    assign imemReq    = imemReqR;
    assign fetchCount = fetchCountR;
    assign opCode     = getOpCode(ifIdInstr);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [25:0] jumpIndex;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [5:0]  opCode;
    logic [31:0] fetchCount;

    int passCount  = 0;
    int totalCount = 0;
    bit cmpEn      = 1'b0;

    // Behavioural model of the fetch stage
    logic [31:0] mPc, mInstr, mPc4, mCount, mHoldI, mHoldP;
    logic        mValid, mJustReset, mHolding;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imemData = memWord(imemAddr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .jump(jump), .jumpIndex(jumpIndex),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemData(imemData), .pc(pc), .ifIdInstr(ifIdInstr),
        .ifIdPcPlus4(ifIdPcPlus4), .ifIdValid(ifIdValid), .opCode(opCode),
        .fetchCount(fetchCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model update from the rules: reset, redirect, post-reset idle, hold, fetch.
    always @(posedge clk) begin
        logic [31:0] nPc, nInstr, nPc4, nCount, nHoldI, nHoldP;
        logic        nValid, nJust, nHolding;
        nPc = mPc; nInstr = mInstr; nPc4 = mPc4; nCount = mCount;
        nHoldI = mHoldI; nHoldP = mHoldP; nValid = mValid;
        nJust = mJustReset; nHolding = mHolding;
        if (!rst_n) begin
            nPc = 32'h0; nInstr = 32'h0; nPc4 = 32'h0; nValid = 1'b0; nCount = 32'h0;
            nJust = 1'b1; nHolding = 1'b0; nHoldI = 32'h0; nHoldP = 32'h0;
        end else if (branchTaken || jump) begin
            nPc = branchTaken ? {branchTarget[31:2], 2'b00} : {mPc4[31:28], jumpIndex, 2'b00};
            nInstr = 32'h0; nValid = 1'b0; nJust = 1'b0; nHolding = 1'b0;
        end else if (mJustReset) begin
            nJust = 1'b0;
        end else if (mHolding) begin
            if (!stall) begin
                nInstr = mHoldI; nPc4 = mHoldP; nValid = 1'b1;
                nCount = mCount + 1; nHolding = 1'b0;
            end
        end else if (imemReady) begin
            if (!stall) begin
                nInstr = memWord(mPc); nPc4 = mPc + 4; nValid = 1'b1; nCount = mCount + 1;
            end else begin
                nHoldI = memWord(mPc); nHoldP = mPc + 4; nHolding = 1'b1;
            end
            nPc = mPc + 4;
        end else if (!stall) begin
            nInstr = 32'h0; nValid = 1'b0;
        end
        mPc <= nPc; mInstr <= nInstr; mPc4 <= nPc4; mCount <= nCount;
        mHoldI <= nHoldI; mHoldP <= nHoldP; mValid <= nValid;
        mJustReset <= nJust; mHolding <= nHolding;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            check("m_imemReq", {31'h0, imemReq}, {31'h0, !mJustReset && !mHolding});
            check("m_imemAddr", imemAddr, mPc);
            check("m_pc", pc, mPc);
            check("m_valid", {31'h0, ifIdValid}, {31'h0, mValid});
            check("m_instr", ifIdInstr, mInstr);
            check("m_opCode", {26'h0, opCode}, {26'h0, mInstr[31:26]});
            check("m_count", fetchCount, mCount);
            if (mValid) check("m_pcPlus4", ifIdPcPlus4, mPc4);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
        jump = 1'b0; jumpIndex = 26'h0; imemReady = 1'b1;
        tick();
        cmpEn = 1'b1;
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, ifIdValid}, 32'h0);
        check("rst_count", fetchCount, 32'h0);
        check("rst_req", {31'h0, imemReq}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_req", {31'h0, imemReq}, 32'h1);
        check("first_pc", pc, 32'h0);
        tick();
        check("seq_pc4", pc, 32'h4);
        check("seq_ifpc4", ifIdPcPlus4, 32'h4);
        check("seq_cnt1", fetchCount, 32'h1);
        check("seq_instr0", ifIdInstr, memWord(32'h0));
        tick();
        check("seq_pc8", pc, 32'h8);
        check("seq_ifpc8", ifIdPcPlus4, 32'h8);
        check("seq_cnt2", fetchCount, 32'h2);
        // stall while the word at 8 returns
        stall = 1'b1;
        tick();
        check("hold_pc", pc, 32'hC);
        check("hold_ifpc", ifIdPcPlus4, 32'h8);
        check("hold_req", {31'h0, imemReq}, 32'h0);
        check("hold_cnt", fetchCount, 32'h2);
        tick();
        check("hold2_instr", ifIdInstr, memWord(32'h4));
        stall = 1'b0;
        tick();
        check("rel_instr", ifIdInstr, memWord(32'h8));
        check("rel_ifpc", ifIdPcPlus4, 32'hC);
        check("rel_valid", {31'h0, ifIdValid}, 32'h1);
        check("rel_cnt", fetchCount, 32'h3);
        imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bub_valid", {31'h0, ifIdValid}, 32'h0);
            check("bub_op", {26'h0, opCode}, 32'h0);
            check("bub_pc", pc, 32'hC);
        end
        imemReady = 1'b1;
        tick();
        check("resume_pc", pc, 32'h10);
        check("resume_cnt", fetchCount, 32'h4);
        branchTaken = 1'b1; branchTarget = 32'h1000_0000;
        tick();
        branchTaken = 1'b0;
        tick();
        check("pre_jump_ifpc", ifIdPcPlus4, 32'h1000_0004);
        jump = 1'b1; jumpIndex = 26'h0000100;
        tick();
        check("jump_pc", pc, 32'h1000_0400);
        check("jump_valid", {31'h0, ifIdValid}, 32'h0);
        branchTaken = 1'b1; branchTarget = 32'h0000_0043;
        tick();
        check("both_pc", pc, 32'h0000_0040);
        check("both_cnt", fetchCount, 32'h5);
        branchTaken = 1'b0; jump = 1'b0;
        tick();
        check("after_both_cnt", fetchCount, 32'h6);
        stall = 1'b1;
        tick();
        check("hold2_pc", pc, 32'h48);
        tick();
        branchTaken = 1'b1; branchTarget = 32'h0000_0200;
        tick();
        check("redir_hold_pc", pc, 32'h200);
        check("redir_hold_valid", {31'h0, ifIdValid}, 32'h0);
        check("redir_hold_cnt", fetchCount, 32'h6);
        check("redir_hold_req", {31'h0, imemReq}, 32'h1);
        branchTaken = 1'b0;
        tick();
        check("hold3_pc", pc, 32'h204);
        rst_n = 1'b0;
        tick();
        check("midhold_rst_pc", pc, 32'h0);
        check("midhold_rst_valid", {31'h0, ifIdValid}, 32'h0);
        check("midhold_rst_cnt", fetchCount, 32'h0);
        check("midhold_rst_req", {31'h0, imemReq}, 32'h0);
        rst_n = 1'b1; stall = 1'b0;
        tick();
        branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        branchTaken = 1'b0;
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_ifpc", ifIdPcPlus4, 32'h0);
        check("wrap_cnt", fetchCount, 32'h1);
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            imemReady    = ($urandom_range(0, 3) != 0);
            branchTaken  = ($urandom_range(0, 15) == 0);
            jump         = mValid && ($urandom_range(0, 15) == 0);
            branchTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom();
            jumpIndex    = 26'($urandom());
            tick();
        end
        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 stall  in  1  hazard hold: PC and IF/ID register keep their values.
REQ-005 branchTaken  in  1  redirect to branchTarget.
REQ-006 branchTarget  in  32  branch destination address.
REQ-007 jump  in  1  redirect to jump target (from Control, decode stage).
REQ-008 jumpIndex  in  26  instruction bits [25:0] of the decoded jump.
REQ-009 imemReq  out  1  instruction memory read request.
REQ-010 imemAddr  out  32  fetch address; equals pc.
REQ-011 imemReady  in  1  imemData valid this cycle.
REQ-012 imemData  in  32  fetched instruction.
REQ-013 pc  out  32  current fetch PC.
REQ-014 ifIdInstr  out  32  IF/ID instruction; 32'h0 when bubble.
REQ-015 ifIdPcPlus4  out  32  IF/ID PC+4 of the held instruction.
REQ-016 ifIdValid  out  1  IF/ID holds a real instruction.
REQ-017 opCode  out  6  ifIdInstr[31:26]; drives Control.opCode.
REQ-018 fetchCount  out  32  instructions delivered into IF/ID.

Function
REQ-019 FSM states: IDLE, WAIT, HOLD; IDLE lasts one cycle after reset, then WAIT.
REQ-020 WAIT: imemReq=1, imemAddr=pc; IDLE and HOLD: imemReq=0.
REQ-021 WAIT, imemReady=1, stall=0, no redirect: IF/ID <= {imemData, pc+4, valid=1}; pc <= pc+4; fetchCount += 1; stay WAIT.
REQ-022 WAIT, imemReady=1, stall=1, no redirect: imemData and pc+4 captured in hold buffer; pc <= pc+4; IF/ID unchanged; go HOLD.
REQ-023 WAIT, imemReady=0: stall=0 -> IF/ID becomes bubble (instr 32'h0, valid=0); stall=1 -> IF/ID unchanged.
REQ-024 HOLD: stall=1 -> no change; stall=0 -> IF/ID <= hold buffer, valid=1, fetchCount += 1, go WAIT.
REQ-025 Redirect = branchTaken | jump; branchTaken has priority when both asserted (older instruction).
REQ-026 Jump target = {ifIdPcPlus4[31:28], jumpIndex, 2'b00}; branchTarget used with bits [1:0] forced to 00.
REQ-027 Redirect in any state: pc <= target, IF/ID becomes bubble, hold buffer discarded, go WAIT; redirect overrides stall.
REQ-028 Redirect coincident with imemReady=1: returned imemData discarded, fetchCount unchanged.
REQ-029 pc[1:0] always 2'b00; pc+4 and fetchCount wrap modulo 2^32 silently.
REQ-030 opCode combinational from ifIdInstr; bubble yields 6'b000000 with instr 0 (sll $0 nop).

Reset
REQ-031 rst_n=0 at a rising edge: pc=RESET_PC, state=IDLE, IF/ID bubble (instr 0, pcPlus4 0, valid 0), hold buffer cleared, fetchCount=0.
REQ-032 Reset overrides stall, redirect and imemReady; a reset during WAIT or HOLD abandons the in-flight fetch.
REQ-033 First imemReq=1 occurs the second cycle after rst_n deasserts (IDLE then WAIT).

Structure
REQ-034 Shared package mips_pkg holds the fetch state enum, NOP_INSTR (32'h0), the default RESET_PC and the opcode field slice constants.
REQ-035 IF/ID register (instr, pcPlus4, valid with load/bubble/hold controls) is a sub-module named if_id_register; PC, FSM and counter live in fetch_stage.

Verification
REQ-036 Reset, imemReady tied 1, imemData=PC-indexed words -> pc 0,4,8,... each cycle after IDLE; ifIdPcPlus4 4,8,12; fetchCount increments by 1 per cycle.
REQ-037 imemReady low 3 cycles, stall=0 -> 3 bubbles (ifIdValid=0, opCode 0), pc unchanged, then normal fetch resumes.
REQ-038 Stall raised the cycle imemReady=1 for pc=8 -> HOLD, IF/ID unchanged, pc=12; stall drops -> IF/ID instr from address 8, valid=1, fetchCount+1.
REQ-039 jump with ifIdPcPlus4=32'h1000_0004, jumpIndex=26'h0000100 -> next pc=32'h1000_0400, IF/ID bubble; branchTaken+jump together with branchTarget=32'h0000_0043 -> pc=32'h0000_0040.
REQ-040 Redirect while stall=1 in HOLD -> hold buffer discarded, pc=target, state WAIT, fetchCount unchanged.
REQ-041 rst_n=0 mid-HOLD with stall=1 -> next cycle pc=RESET_PC, ifIdValid=0, fetchCount=0, imemReq=0.
